// File: rtl/rv_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_pkg
// Purpose  : Shared encodings for the RV32I multi-cycle control sequencer:
//            FSM state codes, opcode/funct fields, ALU op, error cause.
// Revision : 1.0  initial release
// ============================================================================
package rv_ctrl_pkg;

  // FSM state codes
  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_FETCH      = 4'd1;
  localparam logic [3:0] S_FETCH_WAIT = 4'd2;
  localparam logic [3:0] S_DECODE     = 4'd3;
  localparam logic [3:0] S_EXEC       = 4'd4;
  localparam logic [3:0] S_MEM        = 4'd5;
  localparam logic [3:0] S_MEM_WAIT   = 4'd6;
  localparam logic [3:0] S_WB         = 4'd7;
  localparam logic [3:0] S_HALT       = 4'd8;
  localparam logic [3:0] S_ERROR      = 4'd9;

  // Major opcodes
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  // funct3 / funct7 values of the implemented subset
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLL = 3'd2,
    ALU_SRL = 3'd3,
    ALU_AND = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BRK = 3'd4,
    CLS_ILL = 3'd5
  } cls_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_cause_e;

  // True when a register index falls outside the implemented file
  function automatic logic reg_bad(input logic [4:0] idx, input int nregs);
    return int'({27'd0, idx}) >= nregs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_mc_ctrl_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_decode
// Purpose  : Combinational instruction classifier: class, ALU op and the
//            register-index range check for the fields the class uses.
// Revision : 1.0  initial release
// ============================================================================
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic [31:0] instr_i,
  output cls_e        cls_o,
  output alu_op_e     alu_op_o,
  output logic        regs_ok_o
);

  logic [6:0] w_opc;
  logic [4:0] w_rd;
  logic [2:0] w_f3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_f7;
  logic       w_use_rd;
  logic       w_use_rs1;
  logic       w_use_rs2;

  assign w_opc = instr_i[6:0];
  assign w_rd  = instr_i[11:7];
  assign w_f3  = instr_i[14:12];
  assign w_rs1 = instr_i[19:15];
  assign w_rs2 = instr_i[24:20];
  assign w_f7  = instr_i[31:25];

  // Classify the encoding and note which register fields it actually reads/writes
  always_comb begin
    cls_o     = CLS_ILL;
    alu_op_o  = ALU_ADD;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    if (instr_i == EBREAK_WORD) begin
      cls_o = CLS_BRK;
    end else begin
      case (w_opc)
        OP_R: begin
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          if (w_f3 == F3_ADD && w_f7 == F7_BASE) begin
            cls_o = CLS_R; alu_op_o = ALU_ADD;
          end else if (w_f3 == F3_ADD && w_f7 == F7_SUB) begin
            cls_o = CLS_R; alu_op_o = ALU_SUB;
          end else if (w_f3 == F3_SLL && w_f7 == F7_BASE) begin
            cls_o = CLS_R; alu_op_o = ALU_SLL;
          end else if (w_f3 == F3_SRL && w_f7 == F7_BASE) begin
            cls_o = CLS_R; alu_op_o = ALU_SRL;
          end
        end
        OP_I: begin
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          if (w_f3 == F3_ADD) begin
            cls_o = CLS_I; alu_op_o = ALU_ADD;
          end else if (w_f3 == F3_AND) begin
            cls_o = CLS_I; alu_op_o = ALU_AND;
          end
        end
        OP_LD: begin
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          if (w_f3 == F3_W) cls_o = CLS_LD;
        end
        OP_ST: begin
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          if (w_f3 == F3_W) cls_o = CLS_ST;
        end
        default: cls_o = CLS_ILL;
      endcase
    end
  end

  assign regs_ok_o = !((w_use_rd  && reg_bad(w_rd,  NREGS)) ||
                       (w_use_rs1 && reg_bad(w_rs1, NREGS)) ||
                       (w_use_rs2 && reg_bad(w_rs2, NREGS)));

endmodule
`default_nettype wire

// File: rtl/rv_mc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rv_mc_ctrl
// Purpose  : Multi-cycle fetch/decode/execute/memory/writeback sequencer for
//            the RV32I simulation core, with req/gnt/rvalid memory handshake,
//            wait timeout, and retired-instruction counter.
// Revision : 1.0  initial release
// ============================================================================
module rv_mc_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int NREGS   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      instr_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_addr_sel_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             rf_we_o,
  output logic             rf_wsel_o,
  output logic [2:0]       alu_op_o,
  output logic             alu_src_b_o,
  output logic             imm_sel_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [1:0]       err_cause_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam int              TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

  logic [3:0]       state_q,     state_d;
  logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
  logic [CNT_W-1:0] instret_q,   instret_d;
  cls_e             cls_q,       cls_d;
  alu_op_e          alu_op_q,    alu_op_d;
  logic             alu_src_b_q, alu_src_b_d;
  logic             imm_sel_q,   imm_sel_d;
  logic             rd_zero_q,   rd_zero_d;
  err_cause_e       err_cause_q, err_cause_d;

  cls_e    w_dec_cls;
  alu_op_e w_dec_op;
  logic    w_dec_regs_ok;
  logic    w_waiting;
  logic    w_got;

  rv_ctrl_decode #(.NREGS(NREGS)) u_decode (
    .instr_i   (instr_i),
    .cls_o     (w_dec_cls),
    .alu_op_o  (w_dec_op),
    .regs_ok_o (w_dec_regs_ok)
  );

  // Next-state, per-instruction control latching, retire count and wait timeout
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    alu_op_d    = alu_op_q;
    alu_src_b_d = alu_src_b_q;
    imm_sel_d   = imm_sel_q;
    rd_zero_d   = rd_zero_q;
    err_cause_d = err_cause_q;
    instret_d   = instret_q;
    to_cnt_d    = '0;
    w_waiting   = 1'b0;
    w_got       = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        w_waiting = 1'b1;
        w_got     = mem_gnt_i;
        if (mem_gnt_i) state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        w_waiting = 1'b1;
        w_got     = mem_rvalid_i;
        if (mem_rvalid_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (w_dec_cls == CLS_BRK) begin
          state_d = S_HALT;
        end else if (w_dec_cls == CLS_ILL || !w_dec_regs_ok) begin
          state_d     = S_ERROR;
          err_cause_d = ERR_ILLEGAL;
        end else begin
          state_d     = S_EXEC;
          cls_d       = w_dec_cls;
          alu_op_d    = w_dec_op;
          alu_src_b_d = (w_dec_cls != CLS_R);
          imm_sel_d   = (w_dec_cls == CLS_ST);
          rd_zero_d   = (instr_i[11:7] == 5'd0);
        end
      end
      S_EXEC: state_d = (cls_q == CLS_LD || cls_q == CLS_ST) ? S_MEM : S_WB;
      S_WB: begin
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_MEM: begin
        w_waiting = 1'b1;
        w_got     = mem_gnt_i;
        if (mem_gnt_i) begin
          if (cls_q == CLS_ST) begin
            instret_d = instret_q + CNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_MEM_WAIT;
          end
        end
      end
      S_MEM_WAIT: begin
        w_waiting = 1'b1;
        w_got     = mem_rvalid_i;
        if (mem_rvalid_i) begin
          instret_d = instret_q + CNT_W'(1);
          state_d   = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
    // A wait state that stays put counts one more cycle; the TIMEOUT-th
    // fruitless cycle ends in ERROR. Any state change leaves the count at 0.
    if (w_waiting && !w_got) begin
      if (to_cnt_q == c_to_last) begin
        state_d     = S_ERROR;
        err_cause_d = ERR_TIMEOUT;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  // State and control registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      instret_q   <= '0;
      cls_q       <= CLS_R;
      alu_op_q    <= ALU_ADD;
      alu_src_b_q <= 1'b0;
      imm_sel_q   <= 1'b0;
      rd_zero_q   <= 1'b0;
      err_cause_q <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      instret_q   <= instret_d;
      cls_q       <= cls_d;
      alu_op_q    <= alu_op_d;
      alu_src_b_q <= alu_src_b_d;
      imm_sel_q   <= imm_sel_d;
      rd_zero_q   <= rd_zero_d;
      err_cause_q <= err_cause_d;
    end
  end

  // Strobes decode straight from the state so reset drops them at once
  assign mem_req_o      = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_addr_sel_o = (state_q == S_MEM);
  assign mem_we_o       = (state_q == S_MEM) && (cls_q == CLS_ST);
  assign ir_we_o        = (state_q == S_FETCH_WAIT) && mem_rvalid_i;
  assign pc_we_o        = (state_q == S_FETCH_WAIT) && mem_rvalid_i;
  assign rf_wsel_o      = (state_q == S_MEM_WAIT) && mem_rvalid_i;
  assign rf_we_o        = ((state_q == S_WB) || rf_wsel_o) && !rd_zero_q;
  assign alu_op_o       = alu_op_q;
  assign alu_src_b_o    = alu_src_b_q;
  assign imm_sel_o      = imm_sel_q;
  assign halted_o       = (state_q == S_HALT);
  assign err_o          = (state_q == S_ERROR);
  assign err_cause_o    = err_cause_q;
  assign instret_o      = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_mc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rv_mc_ctrl
// Purpose  : Directed bench for rv_mc_ctrl: small instruction memory model
//            with programmable grant/read latency, vector table of programs
//            plus cycle-exact and asynchronous-reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_rv_mc_ctrl;

  localparam logic [31:0] E = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr;
  logic        mem_req, mem_we, mem_addr_sel, gnt, rvalid;
  logic        ir_we, pc_we, rf_we, rf_wsel, alu_src_b, imm_sel, halted, err;
  logic [2:0]  alu_op;
  logic [1:0]  err_cause;
  logic [31:0] instret;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  rv_mc_ctrl #(.CNT_W(32), .TIMEOUT(16), .NREGS(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .instr_i(instr),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_sel_o(mem_addr_sel),
    .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .ir_we_o(ir_we), .pc_we_o(pc_we),
    .rf_we_o(rf_we), .rf_wsel_o(rf_wsel), .alu_op_o(alu_op),
    .alu_src_b_o(alu_src_b), .imm_sel_o(imm_sel), .halted_o(halted),
    .err_o(err), .err_cause_o(err_cause), .instret_o(instret)
  );

  // ---------------- memory / datapath model ----------------
  logic [31:0] prog [16];
  logic [31:0] pc_m, ir_m;
  int          gnt_lat, rv_lat, req_cnt, rv_cnt;
  logic        pend;

  assign instr  = ir_m;
  assign gnt    = mem_req && (req_cnt >= gnt_lat);
  assign rvalid = pend && (rv_cnt >= rv_lat);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_m <= '0; ir_m <= '0; req_cnt <= 0; rv_cnt <= 0; pend <= 1'b0;
    end else begin
      if (ir_we) ir_m <= prog[pc_m[3:0]];
      if (pc_we) pc_m <= pc_m + 32'd1;
      if (mem_req && !gnt) req_cnt <= req_cnt + 1;
      else                 req_cnt <= 0;
      if (gnt && !mem_we) begin
        pend <= 1'b1; rv_cnt <= 1;
      end else if (pend) begin
        if (rvalid) pend <= 1'b0;
        else        rv_cnt <= rv_cnt + 1;
      end
    end
  end

  // ---------------- event monitor ----------------
  logic       mon_clr = 1'b1;
  int         n_irwe, n_rfwe, n_wsel, n_st, n_st_bad;
  logic [3:0] last_op;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_irwe <= 0; n_rfwe <= 0; n_wsel <= 0; n_st <= 0; n_st_bad <= 0; last_op <= '0;
    end else begin
      if (ir_we) n_irwe <= n_irwe + 1;
      if (rf_we) begin
        n_rfwe  <= n_rfwe + 1;
        last_op <= {alu_src_b, alu_op};
        if (rf_wsel) n_wsel <= n_wsel + 1;
      end
      if (mem_we) begin
        n_st <= n_st + 1;
        if (!imm_sel || !alu_src_b || !mem_addr_sel || rf_we) n_st_bad <= n_st_bad + 1;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input int gl, input int rl);
    rst_n = 1'b0; mon_clr = 1'b1; start = 1'b0;
    for (int k = 0; k < 16; k++) prog[k] = E;
    prog[0] = w0; prog[1] = w1; prog[2] = w2;
    gnt_lat = gl; rv_lat = rl;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       nm;
    logic [31:0] w0, w1, w2;
    int          gl, rl;
    logic        halt, err;
    int          cause, instret, rfwe, wsel, st, fetch;
    logic [3:0]  lastop;
  } vec_t;

  vec_t vt [20];

  task automatic run_vec(input vec_t v);
    int cyc;
    int noisy;
    do_reset(v.w0, v.w1, v.w2, v.gl, v.rl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(halted || err) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 1000) begin
      n_cmp++; n_mis++;
      $display("FAIL %s/terminate: got no halt/err expected terminal state", v.nm);
    end
    // terminal states ignore start and keep every strobe low
    noisy = 0;
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_req || ir_we || pc_we || rf_we || mem_we) noisy++;
    end
    start = 1'b0;
    chk({v.nm, "/quiet"},    noisy,     0);
    chk({v.nm, "/halted"},   halted,    v.halt);
    chk({v.nm, "/err"},      err,       v.err);
    chk({v.nm, "/cause"},    err_cause, v.cause);
    chk({v.nm, "/instret"},  instret,   v.instret);
    chk({v.nm, "/rf_we"},    n_rfwe,    v.rfwe);
    chk({v.nm, "/rf_wsel"},  n_wsel,    v.wsel);
    chk({v.nm, "/stores"},   n_st,      v.st);
    chk({v.nm, "/st_ctrl"},  n_st_bad,  0);
    chk({v.nm, "/fetches"},  n_irwe,    v.fetch);
    if (v.rfwe > 0) chk({v.nm, "/alu_ctl"}, last_op, v.lastop);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ir_cyc, rf_cyc, op_exec, req_mask, pre_req, cyc;
    //         name      w0            w1            w2            gl  rl halt err c  ins rfwe wsel st fetch lastop
    vt[0]  = '{"add",    32'h002081B3, E,            E,            0,  1, 1, 0, 0, 1, 1, 0, 0, 2, 4'd0};
    vt[1]  = '{"addi_x0",32'h00100013, E,            E,            0,  1, 1, 0, 0, 1, 0, 0, 0, 2, 4'd0};
    vt[2]  = '{"zero",   32'h00000000, E,            E,            0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 4'd0};
    vt[3]  = '{"rd17",   32'h002088B3, E,            E,            0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 4'd0};
    vt[4]  = '{"lw_sw",  32'h0040A283, 32'h0050A423, E,            0,  3, 1, 0, 0, 2, 1, 1, 1, 3, 4'd8};
    vt[5]  = '{"add2",   32'h002081B3, 32'h002081B3, E,            0,  1, 1, 0, 0, 2, 2, 0, 0, 3, 4'd0};
    vt[6]  = '{"sub",    32'h402081B3, E,            E,            0,  1, 1, 0, 0, 1, 1, 0, 0, 2, 4'd1};
    vt[7]  = '{"shifts", 32'h402081B3, 32'h002091B3, 32'h0020D1B3, 0,  1, 1, 0, 0, 3, 3, 0, 0, 4, 4'd3};
    vt[8]  = '{"andi",   32'h0070F213, E,            E,            0,  1, 1, 0, 0, 1, 1, 0, 0, 2, 4'd12};
    vt[9]  = '{"sra",    32'h4020D1B3, E,            E,            0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 4'd0};
    vt[10] = '{"lb",     32'h00008283, E,            E,            0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 4'd0};
    vt[11] = '{"sw_rs2", 32'h0100A423, E,            E,            0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 4'd0};
    vt[12] = '{"rs1_17", 32'h00088093, E,            E,            0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 4'd0};
    vt[13] = '{"gnt_to", 32'h002081B3, E,            E,            100,1, 0, 1, 2, 0, 0, 0, 0, 0, 4'd0};
    vt[14] = '{"gnt_16", 32'h002081B3, E,            E,            15, 1, 1, 0, 0, 1, 1, 0, 0, 2, 4'd0};
    vt[15] = '{"rv_16",  32'h002081B3, E,            E,            0, 16, 1, 0, 0, 1, 1, 0, 0, 2, 4'd0};
    vt[16] = '{"rv_to",  32'h002081B3, E,            E,            0, 17, 0, 1, 2, 0, 0, 0, 0, 0, 4'd0};
    vt[17] = '{"lw_x0",  32'h0040A003, E,            E,            0,  1, 1, 0, 0, 1, 0, 0, 0, 2, 4'd0};
    vt[18] = '{"add_ill",32'h002081B3, 32'h00000000, E,            0,  1, 0, 1, 1, 1, 1, 0, 0, 2, 4'd0};
    vt[19] = '{"ecall",  32'h00000073, E,            E,            0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 4'd0};

    // ---- reset state, asserted and with the clock running ----
    rst_n = 1'b0;
    gnt_lat = 0; rv_lat = 1;
    for (int k = 0; k < 16; k++) prog[k] = E;
    repeat (3) @(negedge clk);
    chk("reset/outputs", {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, rf_wsel,
                          alu_op, alu_src_b, imm_sel, halted, err, err_cause}, 0);
    chk("reset/instret", instret, 0);

    // ---- cycle-exact ADD: IDLE waits, ir_we at cycle 2, rf_we at cycle 5 ----
    do_reset(32'h002081B3, E, E, 0, 1);
    pre_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_req) pre_req++;
    end
    chk("idle/no_req", pre_req, 0);
    start = 1'b1;
    ir_cyc = 0; rf_cyc = 0; op_exec = 7; req_mask = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (ir_we)  ir_cyc = (ir_cyc == 0) ? k : 99;
      if (rf_we)  rf_cyc = (rf_cyc == 0) ? k : 99;
      if (mem_req) req_mask |= (1 << k);
      if (k == 4) op_exec = int'(alu_op);
    end
    chk("add/ir_we_cycle", ir_cyc, 2);
    chk("add/rf_we_cycle", rf_cyc, 5);
    chk("add/req_cycles",  req_mask, 32'h42);
    chk("add/alu_op_exec", op_exec, 0);
    chk("add/instret",     instret, 1);

    // ---- table-driven programs ----
    foreach (vt[i]) run_vec(vt[i]);

    // ---- async reset drops a pending fetch request ----
    do_reset(32'h002081B3, E, E, 100, 1);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("fetch/req_held", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("fetch_rst/req", mem_req, 0);
    @(negedge clk);

    // ---- async reset in MEM_WAIT of a load after one retired ADD ----
    do_reset(32'h002081B3, 32'h0040A283, E, 0, 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(mem_req && mem_addr_sel && gnt) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("memwait/reach", (cyc < 200), 1);
    @(negedge clk);
    chk("memwait/src_b", alu_src_b, 1);
    chk("memwait/instret", instret, 1);
    #2 rst_n = 1'b0;
    #1 begin
      chk("memwait_rst/outputs", {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, rf_wsel,
                                  alu_op, alu_src_b, imm_sel, halted, err, err_cause}, 0);
      chk("memwait_rst/instret", instret, 0);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_mc_ctrl.md
Name: rv_mc_ctrl

Overview:
Multi-cycle control FSM for the RV32I simulation core (16-entry regfile, word-addressed unified memory). It sequences fetch, decode, execute, memory and writeback, and drives every datapath enable: IR load, PC increment, regfile write, ALU op/source, and memory request. Memory uses a req/gnt/rvalid handshake so the core can later share memory with other masters. It replaces the single `always #step` loop with a clocked, cycle-exact sequencer.

Parameters:
CNT_W, 32, width of retired-instruction counter
TIMEOUT, 16, max cycles waiting for mem_gnt_i or mem_rvalid_i before error
NREGS, 16, implemented registers; register index >= NREGS is illegal

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  leave IDLE and begin fetching
instr_i  in  32  current IR contents, valid from DECODE onward
mem_req_o  out  1  memory request, held until granted
mem_we_o  out  1  1 = store (SW), 0 = read
mem_addr_sel_o  out  1  0 = PC, 1 = ALU result
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid this cycle
ir_we_o  out  1  load IR from memory read data
pc_we_o  out  1  PC <= PC + 1
rf_we_o  out  1  regfile write strobe
rf_wsel_o  out  1  0 = ALU result, 1 = memory read data
alu_op_o  out  3  0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 AND
alu_src_b_o  out  1  0 = rs2, 1 = immediate
imm_sel_o  out  1  0 = I-type, 1 = S-type
halted_o  out  1  EBREAK reached (sticky)
err_o  out  1  error state (sticky)
err_cause_o  out  2  0 none, 1 illegal instruction, 2 memory timeout
instret_o  out  CNT_W  retired instruction count

Behaviour:
- Reset (async, rst_ni=0): state IDLE; all outputs 0; instret_o=0; timeout counter 0. Reset mid-transaction aborts the transaction and drops mem_req_o immediately.
- States: IDLE, FETCH, FETCH_WAIT, DECODE, EXEC, MEM, MEM_WAIT, WB, HALT, ERROR.
- IDLE: start_i=1 -> FETCH next cycle. start_i is ignored in all other states.
- FETCH: mem_req_o=1, mem_addr_sel_o=0, mem_we_o=0. mem_gnt_i=1 -> FETCH_WAIT.
- FETCH_WAIT: on mem_rvalid_i=1, ir_we_o=1 and pc_we_o=1 in the same cycle (Mealy, single-cycle pulse) -> DECODE.
- DECODE: classify instr_i. Legal encodings:
  - ADD/SUB/SLL/SRL: opcode 0110011; (f3,f7) = (000,0000000), (000,0100000), (001,0000000), (101,0000000).
  - ADDI/ANDI: opcode 0010011; f3 000/111.
  - LW: opcode 0000011, f3 010.
  - SW: opcode 0100011, f3 010.
  - EBREAK: exactly 0x00100073.
  - Any used rs1/rs2/rd index >= NREGS is illegal.
  - Transitions: legal -> EXEC; EBREAK -> HALT (not counted in instret); otherwise -> ERROR with cause 1.
- EXEC: 1 cycle; drive alu_op_o, alu_src_b_o and imm_sel_o (S for SW, I otherwise). R/I-type -> WB; LW/SW -> MEM. ALU controls stay stable through WB/MEM/MEM_WAIT of the same instruction.
- WB: rf_we_o=1 and rf_wsel_o=0 for one cycle; instret++ -> FETCH.
- MEM: mem_req_o=1, mem_addr_sel_o=1, mem_we_o=(SW). On gnt: SW retires (instret++) -> FETCH; LW -> MEM_WAIT.
- MEM_WAIT: on mem_rvalid_i=1, rf_we_o=1 and rf_wsel_o=1 in the same cycle; instret++ -> FETCH.
- rd=x0: rf_we_o is suppressed. The instruction still retires.
- Timeout: counter clears on entry to FETCH/FETCH_WAIT/MEM/MEM_WAIT and increments each waiting cycle. When it reaches TIMEOUT without the awaited gnt/rvalid -> ERROR with cause 2. A gnt/rvalid arriving in the same cycle as the TIMEOUT-th wait cycle is accepted (no error).
- mem_rvalid_i outside FETCH_WAIT/MEM_WAIT and mem_gnt_i without a request are ignored.
- HALT/ERROR: terminal until reset. All strobes 0; halted_o or err_o held at 1.
- instret_o wraps modulo 2^CNT_W.
- Best case CPI: R-type 5 cycles (FETCH, FETCH_WAIT, DECODE, EXEC, WB); SW 5; LW 6.

Decomposition:
- Package rv_ctrl_pkg: state enum; opcode/funct3/funct7 constants; alu_op enum; err_cause enum; EBREAK word.
- Sub-module rv_ctrl_decode: purely combinational. Takes instr_i; returns class (R/I/LD/ST/BRK/ILL), alu_op, and the register-range check. The FSM stays in rv_mc_ctrl.

Test Plan:
- Reset, start_i=1, memory gnt+rvalid 1 cycle after req, instr ADD x3,x1,x2 (0x002081B3): ir_we_o at cycle 2, rf_we_o at cycle 5, alu_op_o=0, instret_o=1.
- LW x5,4(x1) then SW x5,8(x1) with 3-cycle rvalid latency: LW sets rf_wsel_o=1 with rf_we_o on rvalid; SW asserts mem_we_o=1, imm_sel_o=1 and never rf_we_o; instret_o=2.
- ADDI x0,x0,1 (0x00100013): no rf_we_o pulse, instret_o increments to 1.
- Instr 0x00000000, then separately ADD x17,x1,x2: each gives err_o=1, err_cause_o=1, mem_req_o stays 0 thereafter.
- Withhold mem_gnt_i for 16 cycles in FETCH: ERROR with cause 2. Repeat with gnt on the 16th cycle: no error.
- EBREAK 0x00100073 after two ADDs: halted_o=1, instret_o=2. Assert rst_ni=0 during MEM_WAIT of a later run: all outputs 0 asynchronously.
